// File: rtl/instruction_buffer_pkg.sv
// Shared types and widths for the fetch-to-dispatch instruction buffer.
package instruction_buffer_pkg;

    // Superscalar width: slots per fetch packet and per dispatch window.
    localparam int NUM_SCALAR      = 3;
    // Default buffer depth in instructions. Must be a power of two and at least NUM_SCALAR.
    localparam int DEFAULT_IB_SZ   = 16;
    // Width of a count in the range 0..NUM_SCALAR.
    localparam int NUM_SCALAR_BITS = $clog2(NUM_SCALAR + 1);

    typedef logic [NUM_SCALAR_BITS-1:0] scalar_cnt_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pred_taken;
    } fetch_entry_t;

    // Slot 0 holds the oldest instruction.
    typedef fetch_entry_t [NUM_SCALAR-1:0] fetch_packet_t;

    // Returns min(value, NUM_SCALAR) as a slot count.
    function automatic scalar_cnt_t clamp_width(input int unsigned value);
        if (value < NUM_SCALAR) begin
            return scalar_cnt_t'(value);
        end
        return scalar_cnt_t'(NUM_SCALAR);
    endfunction

endpackage

// File: rtl/instruction_buffer_if.sv
// Fetch/dispatch-facing bundle of the instruction buffer. The master side
// is the fetch and dispatch logic; the slave side is the buffer itself.
interface instruction_buffer_if;
    import instruction_buffer_pkg::*;

    fetch_packet_t fetch_packet;
    scalar_cnt_t   fetch_valid;
    scalar_cnt_t   ib_spots;
    fetch_packet_t instruction_packets;
    scalar_cnt_t   instructions_valid;
    scalar_cnt_t   num_dispatched;
    logic          restore_valid;

    modport master (
        output fetch_packet,
        output fetch_valid,
        output num_dispatched,
        output restore_valid,
        input  ib_spots,
        input  instruction_packets,
        input  instructions_valid
    );

    modport slave (
        input  fetch_packet,
        input  fetch_valid,
        input  num_dispatched,
        input  restore_valid,
        output ib_spots,
        output instruction_packets,
        output instructions_valid
    );

endinterface

// File: rtl/instruction_buffer_sva.sv
// Protocol and occupancy checks for the instruction buffer. Fetch overrun
// checking can be switched off for benches that deliberately overdrive fetch
// to exercise the silent-drop behaviour.
module instruction_buffer_sva
    import instruction_buffer_pkg::*;
#(
    parameter int IB_SZ             = DEFAULT_IB_SZ,
    parameter int CNT_BITS          = $clog2(IB_SZ + 1),
    parameter int PTR_BITS          = $clog2(IB_SZ),
    parameter bit CHECK_FETCH_LIMIT = 1'b1
) (
    input logic                clock,
    input logic                reset,
    input scalar_cnt_t         fetch_valid,
    input scalar_cnt_t         ib_spots,
    input scalar_cnt_t         num_dispatched,
    input scalar_cnt_t         instructions_valid,
    input logic                restore_valid,
    input logic [PTR_BITS-1:0] head,
    input logic [PTR_BITS-1:0] tail,
    input logic [CNT_BITS-1:0] count
);

    if (CHECK_FETCH_LIMIT) begin : g_fetch_limit
        a_fetch_limit: assert property (@(posedge clock) disable iff (reset)
            !restore_valid |-> (fetch_valid <= ib_spots));
    end

    a_dispatch_limit: assert property (@(posedge clock) disable iff (reset)
        num_dispatched <= instructions_valid);

    a_count_range: assert property (@(posedge clock) disable iff (reset)
        count <= CNT_BITS'(IB_SZ));

    a_count_matches_ptrs: assert property (@(posedge clock) disable iff (reset)
        count[PTR_BITS-1:0] == PTR_BITS'(tail - head));

    a_count_when_equal: assert property (@(posedge clock) disable iff (reset)
        (tail == head) |-> ((count == '0) || (count == CNT_BITS'(IB_SZ))));

endmodule

// File: rtl/instruction_buffer.sv
// Circular FIFO between fetch and dispatch. Accepts up to N instructions per
// cycle, presents the oldest N to dispatch, retires what dispatch consumed,
// and empties on a branch-stack restore. Every output is derived from
// registered state only, because dispatch computes num_dispatched from
// instructions_valid in the same cycle.
module instruction_buffer
    import instruction_buffer_pkg::*;
#(
    parameter int N                 = NUM_SCALAR,
    parameter int IB_SZ             = DEFAULT_IB_SZ,
    parameter int CNT_BITS          = $clog2(IB_SZ + 1),
    parameter bit CHECK_FETCH_LIMIT = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    instruction_buffer_if.slave ib
);

    localparam int PTR_BITS = $clog2(IB_SZ);

    fetch_entry_t        entries [IB_SZ];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [CNT_BITS-1:0] count;
    scalar_cnt_t         accepted;
    logic [CNT_BITS:0]   count_next;

    // Occupancy-derived handshake counts; freed space is only credited next cycle.
    always_comb begin
        ib.ib_spots           = clamp_width(IB_SZ - 32'(count));
        ib.instructions_valid = clamp_width(32'(count));
    end

    // Present the oldest entries from head onward, zeroing slots that are not valid.
    always_comb begin
        ib.instruction_packets = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(ib.instructions_valid)) begin
                ib.instruction_packets[i] = entries[head + PTR_BITS'(i)];
            end
        end
    end

    // Accept count clips fetch to the advertised space, and the occupancy is
    // updated one bit wider so the intermediate sum cannot wrap.
    always_comb begin
        accepted   = (ib.fetch_valid < ib.ib_spots) ? ib.fetch_valid : ib.ib_spots;
        count_next = {1'b0, count}
                   + (CNT_BITS + 1)'(accepted)
                   - (CNT_BITS + 1)'(ib.num_dispatched);
    end

    // Entry storage has no reset; only the pointers decide what is visible.
    always_ff @(posedge clock) begin
        if (!reset && !ib.restore_valid) begin
            for (int i = 0; i < N; i++) begin
                if (i < int'(accepted)) begin
                    entries[tail + PTR_BITS'(i)] <= ib.fetch_packet[i];
                end
            end
        end
    end

    // Pointer and occupancy update; reset and restore both empty the buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (ib.restore_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_BITS'(ib.num_dispatched);
            tail  <= tail + PTR_BITS'(accepted);
            count <= count_next[CNT_BITS-1:0];
        end
    end

    instruction_buffer_sva #(
        .IB_SZ             (IB_SZ),
        .CNT_BITS          (CNT_BITS),
        .PTR_BITS          (PTR_BITS),
        .CHECK_FETCH_LIMIT (CHECK_FETCH_LIMIT)
    ) u_sva (
        .clock              (clock),
        .reset              (reset),
        .fetch_valid        (ib.fetch_valid),
        .ib_spots           (ib.ib_spots),
        .num_dispatched     (ib.num_dispatched),
        .instructions_valid (ib.instructions_valid),
        .restore_valid      (ib.restore_valid),
        .head               (head),
        .tail               (tail),
        .count              (count)
    );

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed scoreboard bench for the instruction buffer with N=3, IB_SZ=8.
// Expected PCs are queued when the bench's own occupancy model says fetch was
// accepted, and are compared against the dispatch window every cycle.
module tb_instruction_buffer;
    import instruction_buffer_pkg::*;

    localparam int TB_IB_SZ = 8;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];
    int          mcount;
    logic [31:0] next_pc;

    instruction_buffer_if ib_bus ();

    instruction_buffer #(
        .N                 (NUM_SCALAR),
        .IB_SZ             (TB_IB_SZ),
        .CHECK_FETCH_LIMIT (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ib    (ib_bus)
    );

    // Free-running 10-time-unit clock.
    always #5 clock = ~clock;

    // Hard stop in case the sequence never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_output(input string tag);
        int exp_valid;
        int exp_spots;
        exp_valid = min_int(mcount, NUM_SCALAR);
        exp_spots = min_int(TB_IB_SZ - mcount, NUM_SCALAR);
        check({tag, ".valid"}, 128'(ib_bus.instructions_valid), 128'(exp_valid));
        check({tag, ".spots"}, 128'(ib_bus.ib_spots), 128'(exp_spots));
        for (int i = 0; i < NUM_SCALAR; i++) begin
            if (i < exp_valid) begin
                check($sformatf("%s.pc%0d", tag, i),
                      128'(ib_bus.instruction_packets[i].pc), 128'(sb[i]));
                check($sformatf("%s.inst%0d", tag, i),
                      128'(ib_bus.instruction_packets[i].inst), 128'({16'hC0DE, sb[i][15:0]}));
            end else begin
                check($sformatf("%s.zero%0d", tag, i),
                      128'(ib_bus.instruction_packets[i]), 128'(0));
            end
        end
    endtask

    // Drive one cycle of fetch/dispatch/restore, then advance the model.
    task automatic apply_stimulus(input int fv, input int nd_req, input bit restore);
        int          spots;
        int          acc;
        int          nd;
        logic [31:0] pc;
        spots = min_int(TB_IB_SZ - mcount, NUM_SCALAR);
        acc   = min_int(fv, spots);
        nd    = restore ? 0 : min_int(nd_req, min_int(mcount, NUM_SCALAR));
        for (int i = 0; i < NUM_SCALAR; i++) begin
            if (i < fv) begin
                pc = next_pc + 32'(4 * i);
                ib_bus.fetch_packet[i].inst       = {16'hC0DE, pc[15:0]};
                ib_bus.fetch_packet[i].pc         = pc;
                ib_bus.fetch_packet[i].npc        = pc + 32'd4;
                ib_bus.fetch_packet[i].pred_taken = 1'b0;
            end else begin
                ib_bus.fetch_packet[i] = '0;
            end
        end
        ib_bus.fetch_valid    = scalar_cnt_t'(fv);
        ib_bus.num_dispatched = scalar_cnt_t'(nd);
        ib_bus.restore_valid  = restore;
        @(posedge clock);
        #1;
        if (restore) begin
            sb.delete();
            mcount = 0;
        end else begin
            for (int i = 0; i < acc; i++) begin
                sb.push_back(next_pc + 32'(4 * i));
            end
            next_pc = next_pc + 32'(4 * acc);
            for (int i = 0; i < nd; i++) begin
                void'(sb.pop_front());
            end
            mcount = mcount + acc - nd;
        end
        ib_bus.fetch_packet   = '0;
        ib_bus.fetch_valid    = '0;
        ib_bus.num_dispatched = '0;
        ib_bus.restore_valid  = 1'b0;
    endtask

    task automatic step(input string tag, input int fv, input int nd, input bit restore);
        check_output(tag);
        apply_stimulus(fv, nd, restore);
    endtask

    initial begin
        reset                 = 1'b1;
        ib_bus.fetch_packet   = '0;
        ib_bus.fetch_valid    = '0;
        ib_bus.num_dispatched = '0;
        ib_bus.restore_valid  = 1'b0;
        mcount                = 0;
        next_pc               = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        check_output("in_reset");
        reset = 1'b0;

        step("idle", 0, 0, 1'b0);
        step("after_idle", 3, 0, 1'b0);
        step("fetch3", 3, 0, 1'b0);
        step("count6", 2, 0, 1'b0);
        step("full", 3, 0, 1'b0);
        step("full_hold1", 3, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            step($sformatf("stream%0d", k), 3, 2, 1'b0);
        end

        step("pre_five", 0, 1, 1'b0);
        step("five", 3, 2, 1'b0);
        step("six", 3, 0, 1'b1);

        next_pc = 32'h100;
        step("flushed", 1, 0, 1'b0);
        step("refill", 0, 1, 1'b0);
        check_output("drained");

        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("reset_again", 0, 0, 1'b0);
        check_output("reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
